// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer controllers.
package dma_pkg;

  localparam int unsigned MEM_AW   = 6;
  localparam int unsigned SDRAM_AW = 8;
  localparam int unsigned MEM_DW   = 256;
  localparam int unsigned SDRAM_DW = 64;
  localparam int unsigned BEATS    = MEM_DW / SDRAM_DW;
  localparam int unsigned BEAT_CW  = $clog2(BEATS);
  localparam int unsigned ST_W     = 3;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_RD_MEM   = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_MEM = 3'd2;
  localparam logic [ST_W-1:0] ST_SEND     = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd4;

  // Select beat idx of a memory word; beat 0 is the least significant slice.
  function automatic logic [SDRAM_DW-1:0] beat_of(input logic [MEM_DW-1:0] w,
                                                  input logic [BEAT_CW-1:0] idx);
    return w[SDRAM_DW*idx +: SDRAM_DW];
  endfunction

endpackage

// File: rtl/dma_mem2sdram_ctrl_if.sv
// Control, memory-read and SDRAM-write signals of the write-back controller.
interface dma_mem2sdram_ctrl_if;
  import dma_pkg::*;

  logic                dma_enbale;
  logic                rw;
  logic                mem_sel;
  logic [MEM_AW-1:0]   latch_mem_src;
  logic [SDRAM_AW-1:0] latch_sdram_beg;
  logic [SDRAM_AW-1:0] latch_sdram_dst;
  logic                mem1_read;
  logic                mem2_read;
  logic [MEM_AW-1:0]   mem_addr;
  logic [MEM_DW-1:0]   mem_rdata;
  logic                sdram_write;
  logic                sdram_ready;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic [SDRAM_DW-1:0] sdram_wdata;
  logic                busy;
  logic                finish;

  modport master (
    input  dma_enbale, rw, mem_sel, latch_mem_src, latch_sdram_beg, latch_sdram_dst,
    input  mem_rdata, sdram_ready,
    output mem1_read, mem2_read, mem_addr, sdram_write, sdram_addr, sdram_wdata,
    output busy, finish
  );

  modport slave (
    output dma_enbale, rw, mem_sel, latch_mem_src, latch_sdram_beg, latch_sdram_dst,
    output mem_rdata, sdram_ready,
    input  mem1_read, mem2_read, mem_addr, sdram_write, sdram_addr, sdram_wdata,
    input  busy, finish
  );

endinterface

// File: rtl/dma_beat_serializer.sv
// Holds one memory word and presents it as a sequence of registered SDRAM beats.
module dma_beat_serializer
  import dma_pkg::*;
(
  input  logic                clk_h,
  input  logic                rst_n,
  input  logic                load_c,
  input  logic                adv_c,
  input  logic [MEM_DW-1:0]   word_in,
  output logic [SDRAM_DW-1:0] beat_q,
  output logic                last_beat_c
);

  logic [MEM_DW-1:0]   word_q, word_d;
  logic [BEAT_CW-1:0]  cnt_q, cnt_d;
  logic [SDRAM_DW-1:0] beat_d;

  assign last_beat_c = (cnt_q == BEAT_CW'(BEATS - 1));

  // Load a fresh word at beat 0, or step to the next beat of the held word.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    beat_d = beat_q;
    if (load_c) begin
      word_d = word_in;
      cnt_d  = '0;
      beat_d = beat_of(word_in, '0);
    end else if (adv_c) begin
      cnt_d  = cnt_q + BEAT_CW'(1);
      beat_d = beat_of(word_q, cnt_q + BEAT_CW'(1));
    end
  end

  // Word, beat index and beat output registers.
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
      beat_q <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/dma_mem2sdram_ctrl.sv
// Write-back DMA: reads 256-bit memory words and writes them to SDRAM as 64-bit beats.
module dma_mem2sdram_ctrl
  import dma_pkg::*;
(
  input  logic                 clk_h,
  input  logic                 rst_n,
  dma_mem2sdram_ctrl_if.master bus
);

  logic [ST_W-1:0]     state_q, state_d;
  logic                mem_sel_q, mem_sel_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;
  logic [SDRAM_AW-1:0] dst_q, dst_d;
  logic                mem1_read_q, mem1_read_d;
  logic                mem2_read_q, mem2_read_d;
  logic                sdram_write_q, sdram_write_d;
  logic                busy_q, busy_d;
  logic                finish_q, finish_d;

  logic                ser_load_c;
  logic                ser_adv_c;
  logic                last_beat_c;
  logic                accept_c;
  logic [SDRAM_DW-1:0] beat_q;

  assign accept_c = sdram_write_q && bus.sdram_ready;

  dma_beat_serializer u_ser (
    .clk_h       (clk_h),
    .rst_n       (rst_n),
    .load_c      (ser_load_c),
    .adv_c       (ser_adv_c),
    .word_in     (bus.mem_rdata),
    .beat_q      (beat_q),
    .last_beat_c (last_beat_c)
  );

  // Next-state and next-output logic; strobes are set one state early so they are registered.
  always_comb begin
    state_d       = state_q;
    mem_sel_d     = mem_sel_q;
    mem_addr_d    = mem_addr_q;
    sdram_addr_d  = sdram_addr_q;
    dst_d         = dst_q;
    mem1_read_d   = 1'b0;
    mem2_read_d   = 1'b0;
    sdram_write_d = sdram_write_q;
    busy_d        = busy_q;
    finish_d      = 1'b0;
    ser_load_c    = 1'b0;
    ser_adv_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d        = 1'b0;
        sdram_write_d = 1'b0;
        if (bus.dma_enbale && bus.rw) begin
          mem_sel_d    = bus.mem_sel;
          mem_addr_d   = bus.latch_mem_src;
          sdram_addr_d = bus.latch_sdram_beg;
          dst_d        = bus.latch_sdram_dst;
          busy_d       = 1'b1;
          mem1_read_d  = !bus.mem_sel;
          mem2_read_d  = bus.mem_sel;
          state_d      = ST_RD_MEM;
        end
      end
      ST_RD_MEM: begin
        state_d = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        ser_load_c    = 1'b1;
        sdram_write_d = 1'b1;
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (accept_c) begin
          if (sdram_addr_q == dst_q) begin
            sdram_write_d = 1'b0;
            finish_d      = 1'b1;
            state_d       = ST_DONE;
          end else begin
            sdram_addr_d = sdram_addr_q + SDRAM_AW'(1);
            if (last_beat_c) begin
              mem_addr_d    = mem_addr_q + MEM_AW'(1);
              sdram_write_d = 1'b0;
              mem1_read_d   = !mem_sel_q;
              mem2_read_d   = mem_sel_q;
              state_d       = ST_RD_MEM;
            end else begin
              ser_adv_c = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d        = 1'b0;
        sdram_write_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mem_sel_q     <= 1'b0;
      mem_addr_q    <= '0;
      sdram_addr_q  <= '0;
      dst_q         <= '0;
      mem1_read_q   <= 1'b0;
      mem2_read_q   <= 1'b0;
      sdram_write_q <= 1'b0;
      busy_q        <= 1'b0;
      finish_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_sel_q     <= mem_sel_d;
      mem_addr_q    <= mem_addr_d;
      sdram_addr_q  <= sdram_addr_d;
      dst_q         <= dst_d;
      mem1_read_q   <= mem1_read_d;
      mem2_read_q   <= mem2_read_d;
      sdram_write_q <= sdram_write_d;
      busy_q        <= busy_d;
      finish_q      <= finish_d;
    end
  end

  assign bus.mem1_read   = mem1_read_q;
  assign bus.mem2_read   = mem2_read_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.sdram_write = sdram_write_q;
  assign bus.sdram_addr  = sdram_addr_q;
  assign bus.sdram_wdata = beat_q;
  assign bus.busy        = busy_q;
  assign bus.finish      = finish_q;

endmodule

// File: tb/tb_dma_mem2sdram_ctrl.sv
// Scoreboard bench for the memory-to-SDRAM write-back controller.
module tb_dma_mem2sdram_ctrl;

  logic clk_h = 1'b0;
  logic rst_n = 1'b0;

  dma_mem2sdram_ctrl_if bus ();

  dma_mem2sdram_ctrl dut (
    .clk_h (clk_h),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk_h = ~clk_h;

  logic [255:0] bank1 [64];
  logic [255:0] bank2 [64];

  logic [6:0]  exp_rd [$];     // {bank, word address}
  logic [71:0] exp_beat [$];   // {sdram address, data}
  int          exp_fin   = 0;
  int          checks    = 0;
  int          failures  = 0;
  int          ready_pct = 100;

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr  = '0;
  logic [63:0] prev_data  = '0;

  task automatic chk(input bit ok, input string name, input logic [255:0] act,
                     input logic [255:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Memory banks: data valid exactly one cycle after the read strobe, garbage otherwise.
  always @(posedge clk_h) begin
    if (bus.mem1_read)      bus.mem_rdata <= bank1[bus.mem_addr];
    else if (bus.mem2_read) bus.mem_rdata <= bank2[bus.mem_addr];
    else bus.mem_rdata <= {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
  end

  // Random SDRAM backpressure.
  initial begin
    bus.sdram_ready = 1'b1;
    forever begin
      @(posedge clk_h);
      #1 bus.sdram_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: compare every DUT read strobe, accepted beat and finish against the scoreboard.
  always @(negedge clk_h) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (bus.mem1_read || bus.mem2_read) begin
        chk(!(bus.mem1_read && bus.mem2_read), "strobe_excl",
            256'({bus.mem1_read, bus.mem2_read}), 256'(0));
        if (exp_rd.size() == 0) begin
          chk(1'b0, "unexpected_read", 256'({bus.mem2_read, bus.mem_addr}), 256'(0));
        end else begin
          logic [6:0] e;
          e = exp_rd.pop_front();
          chk({bus.mem2_read, bus.mem_addr} == e, "mem_read",
              256'({bus.mem2_read, bus.mem_addr}), 256'(e));
        end
      end
      if (prev_stall) begin
        chk(bus.sdram_write && bus.sdram_addr == prev_addr && bus.sdram_wdata == prev_data,
            "stall_hold", 256'({bus.sdram_write, bus.sdram_addr, bus.sdram_wdata}),
            256'({1'b1, prev_addr, prev_data}));
      end
      if (bus.sdram_write && bus.sdram_ready) begin
        if (exp_beat.size() == 0) begin
          chk(1'b0, "unexpected_beat", 256'({bus.sdram_addr, bus.sdram_wdata}), 256'(0));
        end else begin
          logic [71:0] b;
          b = exp_beat.pop_front();
          chk({bus.sdram_addr, bus.sdram_wdata} == b, "beat",
              256'({bus.sdram_addr, bus.sdram_wdata}), 256'(b));
        end
      end
      if (bus.finish) begin
        chk(exp_fin > 0, "unexpected_finish", 256'(exp_fin), 256'(1));
        chk(exp_beat.size() == 0 && exp_rd.size() == 0 && bus.busy, "finish_state",
            256'({exp_beat.size(), exp_rd.size(), bus.busy}), 256'(1));
        if (exp_fin > 0) exp_fin--;
      end
      prev_stall <= bus.sdram_write && !bus.sdram_ready;
      prev_addr  <= bus.sdram_addr;
      prev_data  <= bus.sdram_wdata;
    end
  end

  // Reference model: beat k goes to beg+k, taken from word src+k/4, slice k%4.
  task automatic push_model(input logic [5:0] src, input logic [7:0] beg,
                            input logic [7:0] dst, input logic sel, output int n);
    logic [255:0] w;
    logic [5:0]   wi;
    n = int'(8'(dst - beg)) + 1;
    for (int k = 0; k < n; k++) begin
      wi = 6'(int'(src) + k / 4);
      w  = sel ? bank2[wi] : bank1[wi];
      if (k % 4 == 0) exp_rd.push_back({sel, wi});
      exp_beat.push_back({8'(int'(beg) + k), w[(k % 4) * 64 +: 64]});
    end
    exp_fin++;
  endtask

  task automatic run_xfer(input logic [5:0] src, input logic [7:0] beg,
                          input logic [7:0] dst, input logic sel, input int pct,
                          input bit chk_lat);
    int n, w, lat;
    bit got;
    push_model(src, beg, dst, sel, n);
    w = (n - 1) / 4 + 1;
    ready_pct = pct;
    @(posedge clk_h);
    #1;
    bus.dma_enbale = 1'b1; bus.rw = 1'b1; bus.mem_sel = sel;
    bus.latch_mem_src = src; bus.latch_sdram_beg = beg; bus.latch_sdram_dst = dst;
    @(posedge clk_h);
    #1;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk_h);
      if (c == 1) begin
        bus.mem_sel = ~sel;
        bus.latch_mem_src = 6'($urandom); bus.latch_sdram_beg = 8'($urandom);
        bus.latch_sdram_dst = 8'($urandom);
      end
      if (c == 2) bus.dma_enbale = 1'b0;
      if (bus.finish) begin
        lat = c; got = 1'b1;
        break;
      end
    end
    bus.dma_enbale = 1'b0;
    chk(got, "finish_timeout", 256'(got), 256'(1));
    if (got && chk_lat) chk(lat == 2 * w + n + 1, "latency", 256'(lat), 256'(2 * w + n + 1));
    @(negedge clk_h);
    chk(!bus.busy && !bus.sdram_write, "idle_after", 256'({bus.busy, bus.sdram_write}), 256'(0));
    ready_pct = 100;
  endtask

  task automatic chk_all_zero(input string name);
    chk({bus.mem1_read, bus.mem2_read, bus.mem_addr, bus.sdram_write, bus.sdram_addr,
         bus.sdram_wdata, bus.busy, bus.finish} == '0, name,
        256'({bus.mem1_read, bus.mem2_read, bus.mem_addr, bus.sdram_write, bus.sdram_addr,
              bus.sdram_wdata, bus.busy, bus.finish}), 256'(0));
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 64; i++) begin
      bank1[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bank2[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    bus.dma_enbale = 1'b0; bus.rw = 1'b0; bus.mem_sel = 1'b0;
    bus.latch_mem_src = '0; bus.latch_sdram_beg = '0; bus.latch_sdram_dst = '0;
    repeat (3) @(negedge clk_h);
    chk_all_zero("reset_state");
    @(posedge clk_h);
    #1 rst_n = 1'b1;

    run_xfer(6'd5,  8'h10, 8'h10, 1'b0, 100, 1'b1);   // single beat
    run_xfer(6'd9,  8'h00, 8'h03, 1'b0, 100, 1'b1);   // one full word
    run_xfer(6'd62, 8'h20, 8'h29, 1'b1, 100, 1'b1);   // multi-word, memory wrap, partial word
    run_xfer(6'd62, 8'h20, 8'h29, 1'b1, 30,  1'b0);   // same under backpressure
    run_xfer(6'd17, 8'hFE, 8'h01, 1'b0, 100, 1'b1);   // SDRAM address wrap

    for (int t = 0; t < 12; t++) begin
      logic [7:0] b;
      int pct;
      b   = 8'($urandom);
      pct = (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 70 : 30);
      run_xfer(6'($urandom), b, 8'(int'(b) + $urandom_range(0, 24)), 1'($urandom),
               pct, pct == 100);
    end

    // Start with rw=0 must be ignored.
    @(posedge clk_h);
    #1 bus.dma_enbale = 1'b1; bus.rw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_h);
      chk(!bus.busy && !bus.sdram_write && !bus.mem1_read && !bus.mem2_read, "rw0_idle",
          256'({bus.busy, bus.sdram_write, bus.mem1_read, bus.mem2_read}), 256'(0));
    end
    bus.dma_enbale = 1'b0; bus.rw = 1'b1;

    // Reset asserted during SEND aborts the transfer silently.
    begin
      int n;
      push_model(6'd3, 8'h40, 8'h4B, 1'b0, n);
      @(posedge clk_h);
      #1 bus.dma_enbale = 1'b1; bus.rw = 1'b1; bus.mem_sel = 1'b0;
      bus.latch_mem_src = 6'd3; bus.latch_sdram_beg = 8'h40; bus.latch_sdram_dst = 8'h4B;
      @(posedge clk_h);
      #1 bus.dma_enbale = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk_h);
        if (bus.sdram_write && bus.sdram_ready && exp_beat.size() <= 8) seen = 1'b1;
      end
      chk(seen, "reach_send", 256'(seen), 256'(1));
      @(posedge clk_h);
      #1 rst_n = 1'b0;
      exp_rd.delete(); exp_beat.delete(); exp_fin = 0;
      #1 chk_all_zero("reset_midsend_async");
      @(negedge clk_h);
      chk_all_zero("reset_midsend_held");
      @(posedge clk_h);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk_h);
        chk(!bus.busy && !bus.finish && !bus.sdram_write, "post_reset_idle",
            256'({bus.busy, bus.finish, bus.sdram_write}), 256'(0));
      end
    end

    run_xfer(6'd0, 8'h80, 8'h86, 1'b1, 100, 1'b1);    // recovery after abort

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
